remote_cmd_sched: RTL

Arbitrates two command requesters onto a single serial command link, the 16-bit-command / 8-bit-response UART transceiver wrapper, and sequences each transaction as send, wait for transmit complete, wait for response. Requesters are granted round-robin. Each granted command completes with exactly one acknowledge: either the response byte or a timeout flag. The block sits between on-chip command sources (e.g. host sequencer, test/debug port) and the command transceiver.

---
 rtl/remote_cmd_sched_pkg.sv | 31 +++
 rtl/remote_cmd_sched_if.sv | 30 +++
 rtl/remote_cmd_sched_rr_arb2.sv | 29 ++
 rtl/remote_cmd_sched.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/remote_cmd_sched_pkg.sv
// Shared types and defaults for the remote command scheduler.
package remote_sched_pkg;

  localparam int unsigned SCHED_TOUT_DFLT  = 1_000_000;
  localparam int unsigned SCHED_RETRY_DFLT = 2;

  localparam int unsigned REQ_N  = 2;
  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    SEND      = 3'd2,
    WAIT_SENT = 3'd3,
    WAIT_RESP = 3'd4,
    DONE      = 3'd5
  } sched_state_t;

  // Completion payload returned to the requester with ack.
  typedef struct packed {
    logic              tout;
    logic [RESP_W-1:0] data;
  } resp_pl_t;

  // One-hot ack vector for a requester id.
  function automatic logic [REQ_N-1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/remote_cmd_sched_if.sv
// Requester-side and transceiver-side signals of the command scheduler.
interface remote_cmd_sched_if;
  import remote_sched_pkg::*;

  logic [REQ_N-1:0]  req;
  logic [CMD_W-1:0]  cmd0;
  logic [CMD_W-1:0]  cmd1;
  logic [REQ_N-1:0]  ack;
  logic [RESP_W-1:0] resp_out;
  logic              tout;
  logic              busy;
  logic              send_cmd;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_sent;
  logic              resp_rdy;
  logic [RESP_W-1:0] resp;

  // Environment side: requesters plus transceiver.
  modport master (
    output req, cmd0, cmd1, cmd_sent, resp_rdy, resp,
    input  ack, resp_out, tout, busy, send_cmd, cmd
  );

  // Scheduler side.
  modport slave (
    input  req, cmd0, cmd1, cmd_sent, resp_rdy, resp,
    output ack, resp_out, tout, busy, send_cmd, cmd
  );

endinterface

// File: rtl/remote_cmd_sched_rr_arb2.sv
// Two-way round-robin arbiter; pointer advances only on an accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_id,
  output logic       gnt_vld
);

  // Requester favoured on the next tie: the one not granted last (0 after reset).
  logic ptr;

  // Grant decode: single request wins outright, a tie goes to the favoured side.
  always_comb begin
    gnt_vld = |req;
    gnt_id  = (req == 2'b11) ? ptr : req[1];
  end

  // Pointer update on an accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (en && gnt_vld) begin
      ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/remote_cmd_sched.sv
// Round-robin command scheduler onto a single serial command link.
// Optional build macro: REMOTE_SCHED_RETRY_EN (resend on timeout up to MAX_RETRY times).
module remote_cmd_sched
  import remote_sched_pkg::*;
#(
  parameter int unsigned TOUT_CYCLES = SCHED_TOUT_DFLT,
  parameter int unsigned MAX_RETRY   = SCHED_RETRY_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  remote_cmd_sched_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOUT_CYCLES - 1);

  sched_state_t      state;
  sched_state_t      state_next;
  logic [CNT_W-1:0]  tcnt;
  logic              id;
  logic [CMD_W-1:0]  cmd_q;
  logic              arb_en;
  logic              gnt_id;
  logic              gnt_vld;
  logic              timeout_c;
  logic              retry_ok_c;

  logic [REQ_N-1:0]  ack_d;
  logic [REQ_N-1:0]  ack_q;
  resp_pl_t          rsp_d;
  resp_pl_t          rsp_q;
  logic              busy_d;
  logic              busy_q;
  logic              send_d;
  logic              send_q;

  assign arb_en    = (state == IDLE);
  assign timeout_c = (tcnt == CNT_LAST);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .en      (arb_en),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

`ifdef REMOTE_SCHED_RETRY_EN
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
  logic [RTY_W-1:0] rty;

  assign retry_ok_c = (rty < RTY_W'(MAX_RETRY));

  // Resend count: cleared per grant, bumped on each timeout-driven resend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rty <= '0;
    end else if (state == GRANT) begin
      rty <= '0;
    end else if ((state == WAIT_SENT || state == WAIT_RESP) && state_next == SEND) begin
      rty <= rty + RTY_W'(1);
    end
  end
`else
  // Retries compiled out; MAX_RETRY is kept so both builds share one parameter list.
  assign retry_ok_c = 1'b0 && (MAX_RETRY != 0);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a response beats a timeout in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (gnt_vld) state_next = GRANT;
      GRANT:     state_next = SEND;
      SEND:      state_next = WAIT_SENT;
      WAIT_SENT, WAIT_RESP: begin
        if (bus.resp_rdy) begin
          state_next = DONE;
        end else if (timeout_c) begin
          state_next = retry_ok_c ? SEND : DONE;
        end else if (state == WAIT_SENT && bus.cmd_sent) begin
          state_next = WAIT_RESP;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs track the state.
  always_comb begin
    ack_d  = '0;
    rsp_d  = '0;
    busy_d = (state_next != IDLE);
    send_d = (state_next == SEND);
    if (state_next == DONE) begin
      ack_d = id_onehot(id);
      if (bus.resp_rdy) begin
        rsp_d.data = bus.resp;
      end else begin
        rsp_d.tout = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= '0;
      rsp_q  <= '0;
      busy_q <= 1'b0;
      send_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      rsp_q  <= rsp_d;
      busy_q <= busy_d;
      send_q <= send_d;
    end
  end

  // Winner id, latched command, and saturating cycles-since-SEND counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id    <= 1'b0;
      cmd_q <= '0;
      tcnt  <= '0;
    end else begin
      if (arb_en && gnt_vld) begin
        id <= gnt_id;
      end
      if (state == GRANT) begin
        cmd_q <= id ? bus.cmd1 : bus.cmd0;
      end
      if (state_next == SEND) begin
        tcnt <= '0;
      end else if ((state == SEND || state == WAIT_SENT || state == WAIT_RESP) && tcnt != '1) begin
        tcnt <= tcnt + CNT_W'(1);
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.resp_out = rsp_q.data;
  assign bus.tout     = rsp_q.tout;
  assign bus.busy     = busy_q;
  assign bus.send_cmd = send_q;
  assign bus.cmd      = cmd_q;

endmodule
